// File: rtl/fp_scheduler.sv
// fp_scheduler: fixed-priority arbiter over NUMBER_OF_QUEUES request queues.
// Picks the non-empty queue with the largest unsigned priority (lowest index
// on ties) and registers its index; all-empty cycles hold the last selection.
module fp_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int PRIORITY_SIZE    = 32
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0]  priorities,
    input  logic [NUMBER_OF_QUEUES-1:0]                     empty,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]             selection
);

    localparam int IW     = $clog2(NUMBER_OF_QUEUES);
    localparam int LEAVES = 2 ** IW;

    // Heap-ordered comparator tree: node 1 is the root, node LEAVES+i is queue i.
    // Leaves beyond NUMBER_OF_QUEUES are padded as invalid entries.
    logic                     node_v [1:2*LEAVES-1];
    logic [PRIORITY_SIZE-1:0] node_p [1:2*LEAVES-1];
    logic [IW-1:0]            node_i [1:2*LEAVES-1];

    // Combinational reduction of (valid, priority, index) triples toward the root
    always_comb begin
        for (int unsigned n = 1; n < 2 * LEAVES; n++) begin
            node_v[n] = 1'b0;
            node_p[n] = '0;
            node_i[n] = '0;
        end
        for (int unsigned q = 0; q < LEAVES; q++) begin
            if (q < NUMBER_OF_QUEUES) begin
                node_v[LEAVES+q] = ~empty[q];
                node_p[LEAVES+q] = priorities[q];
                node_i[LEAVES+q] = IW'(q);
            end
        end
        // Left child covers lower indices, so it wins whenever the right one
        // does not strictly beat it.
        for (int unsigned n = LEAVES - 1; n >= 1; n--) begin
            if (node_v[2*n+1] && (!node_v[2*n] || (node_p[2*n+1] > node_p[2*n]))) begin
                node_v[n] = 1'b1;
                node_p[n] = node_p[2*n+1];
                node_i[n] = node_i[2*n+1];
            end else begin
                node_v[n] = node_v[2*n];
                node_p[n] = node_p[2*n];
                node_i[n] = node_i[2*n];
            end
        end
    end

    // Register the winning index; hold the previous grant when every queue is empty
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            selection <= '0;
        end else if (node_v[1]) begin
            selection <= node_i[1];
        end
    end

endmodule

// File: tb/tb_fp_scheduler.sv
// tb_fp_scheduler: directed self-checking bench for fp_scheduler (4 queues, 32-bit priorities).
module tb_fp_scheduler;

    logic              clock;
    logic              reset;
    logic [3:0][31:0]  priorities;
    logic [3:0]        empty;
    logic [1:0]        selection;

    int passed;
    int total;

    fp_scheduler #(
        .NUMBER_OF_QUEUES(4),
        .PRIORITY_SIZE(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .priorities(priorities),
        .empty(empty),
        .selection(selection)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_prio(input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] p2, input logic [31:0] p3);
        priorities[0] = p0;
        priorities[1] = p1;
        priorities[2] = p2;
        priorities[3] = p3;
    endtask

    // Drive empty away from the active edge, then sample just after the next rising edge
    task automatic apply(input logic [3:0] e);
        @(negedge clock);
        empty = e;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b0;
        #2;
        total++;
        if (selection !== 2'd0) $display("FAIL reset_async: got %0d expected 0", selection);
        else passed++;
        @(negedge clock);
        set_prio(32'd15, 32'd14, 32'd13, 32'd12);
        reset = 1'b1;
        apply(4'b0000);
        total++;
        if (selection !== 2'd0) $display("FAIL reset_release: got %0d expected 0", selection);
        else passed++;
    endtask

    task automatic test_single_candidate();
        logic [3:0] e;
        set_prio(32'd15, 32'd14, 32'd13, 32'd12);
        for (int i = 0; i < 4; i++) begin
            e = 4'b1111;
            e[i] = 1'b0;
            apply(e);
            total++;
            if (selection !== 2'(i)) $display("FAIL single_q%0d: got %0d expected %0d", i, selection, i);
            else passed++;
        end
        // Lone candidate wins even with priority 0
        set_prio(32'd15, 32'd14, 32'd13, 32'd0);
        apply(4'b1101);
        apply(4'b0111);
        total++;
        if (selection !== 2'd3) $display("FAIL single_zero_prio: got %0d expected 3", selection);
        else passed++;
    endtask

    task automatic test_priority_order();
        set_prio(32'd15, 32'd14, 32'd13, 32'd12);
        apply(4'b1001);
        total++;
        if (selection !== 2'd1) $display("FAIL order_1001: got %0d expected 1", selection);
        else passed++;
        apply(4'b0011);
        total++;
        if (selection !== 2'd2) $display("FAIL order_0011: got %0d expected 2", selection);
        else passed++;
        set_prio(32'd1, 32'd2, 32'd3, 32'd9);
        apply(4'b0000);
        total++;
        if (selection !== 2'd3) $display("FAIL order_rev: got %0d expected 3", selection);
        else passed++;
    endtask

    task automatic test_max_priority();
        // All-ones and MSB-set values must compare as unsigned
        set_prio(32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5);
        apply(4'b0000);
        total++;
        if (selection !== 2'd1) $display("FAIL max_prio: got %0d expected 1", selection);
        else passed++;
        apply(4'b0010);
        total++;
        if (selection !== 2'd2) $display("FAIL msb_prio: got %0d expected 2", selection);
        else passed++;
    endtask

    task automatic test_ties();
        set_prio(32'd7, 32'd7, 32'd7, 32'd7);
        apply(4'b0000);
        total++;
        if (selection !== 2'd0) $display("FAIL tie_all: got %0d expected 0", selection);
        else passed++;
        apply(4'b1001);
        total++;
        if (selection !== 2'd1) $display("FAIL tie_1001: got %0d expected 1", selection);
        else passed++;
    endtask

    task automatic test_all_empty_hold();
        set_prio(32'd15, 32'd14, 32'd13, 32'd12);
        apply(4'b0011);
        total++;
        if (selection !== 2'd2) $display("FAIL hold_setup: got %0d expected 2", selection);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            apply(4'b1111);
            total++;
            if (selection !== 2'd2) $display("FAIL hold_cycle%0d: got %0d expected 2", c, selection);
            else passed++;
        end
        apply(4'b0111);
        total++;
        if (selection !== 2'd3) $display("FAIL hold_exit: got %0d expected 3", selection);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        total++;
        if (selection !== 2'd3) $display("FAIL midreset_setup: got %0d expected 3", selection);
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (selection !== 2'd0) $display("FAIL midreset_async: got %0d expected 0", selection);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        empty = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            apply(4'b1111);
            total++;
            if (selection !== 2'd0) $display("FAIL midreset_hold%0d: got %0d expected 0", c, selection);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        empty  = 4'b0000;
        set_prio(32'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_single_candidate();
        test_priority_order();
        test_max_priority();
        test_ties();
        test_all_empty_hold();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
